// File: rtl/envelope_limiter.sv
// Envelope-tracking dynamics limiter for the 16-bit signed sample path.
// Gain is reduced by a serial restoring divide so peaks settle at the threshold.
module envelope_limiter #(
  parameter int unsigned BITS_PER_LEVEL = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [15:0] in_sample,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic        [14:0] threshold,
  input  logic        [3:0]  attack_shift,
  input  logic        [3:0]  release_shift,
  output logic signed [15:0] out_sample,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               gain_reduction
);

  localparam int unsigned SW = 16;
  localparam int unsigned EW = 15;
  localparam int unsigned SHW = 4;
  localparam int unsigned GW = BITS_PER_LEVEL + 1;
  localparam int unsigned CW = $clog2(BITS_PER_LEVEL + 1);
  localparam int unsigned PW = SW + GW + 1;

  localparam logic [GW-1:0]        UNITY = GW'(1) << BITS_PER_LEVEL;
  localparam logic signed [PW-1:0] MAX_V = PW'(32767);
  localparam logic signed [PW-1:0] MIN_V = PW'(-32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENV,
    S_DIV,
    S_APPLY,
    S_HOLD
  } state_e;

  state_e state_q, state_d;

  logic signed [SW-1:0]  sample_q, sample_d;
  logic        [EW-1:0]  thr_q, thr_d;
  logic        [SHW-1:0] atk_q, atk_d;
  logic        [SHW-1:0] rel_q, rel_d;
  logic        [EW-1:0]  env_q, env_d;
  logic        [EW-1:0]  rem_q, rem_d;
  logic        [GW-1:0]  gain_q, gain_d;
  logic        [CW-1:0]  cnt_q, cnt_d;
  logic signed [SW-1:0]  out_sample_q, out_sample_d;
  logic                  out_valid_q, out_valid_d;
  logic                  gain_red_q, gain_red_d;
  logic                  in_ready_q, in_ready_d;

  logic        [EW-1:0]  abs_s;
  logic        [EW-1:0]  env_new;
  logic                  limit;
  logic        [EW:0]    rem_sh;
  logic                  rem_ge;
  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  prod_sh;
  logic signed [SW-1:0]  prod_clamped;

  assign in_ready       = in_ready_q;
  assign out_sample     = out_sample_q;
  assign out_valid      = out_valid_q;
  assign gain_reduction = gain_red_q;

  // Saturated magnitude, envelope step, divider step and scaled product.
  always_comb begin
    if (sample_q == 16'sh8000) begin
      abs_s = 15'h7FFF;
    end else if (sample_q[SW-1]) begin
      abs_s = EW'(-sample_q);
    end else begin
      abs_s = EW'(sample_q);
    end

    if (abs_s > env_q) begin
      env_new = env_q + ((abs_s - env_q) >> atk_q);
    end else begin
      env_new = env_q - ((env_q - abs_s) >> rel_q);
    end
    limit = (env_new > thr_q);

    rem_sh = {rem_q, 1'b0};
    rem_ge = (rem_sh >= {1'b0, env_q});

    prod    = PW'(sample_q) * PW'($signed({1'b0, gain_q}));
    prod_sh = prod >>> BITS_PER_LEVEL;
    if (prod_sh > MAX_V) begin
      prod_clamped = 16'sh7FFF;
    end else if (prod_sh < MIN_V) begin
      prod_clamped = 16'sh8000;
    end else begin
      prod_clamped = SW'(prod_sh);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid && in_ready_q) state_d = S_ENV;
      S_ENV:   state_d = limit ? S_DIV : S_APPLY;
      S_DIV:   if (cnt_q == '0) state_d = S_APPLY;
      S_APPLY: state_d = S_HOLD;
      S_HOLD:  if (out_valid_q && out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sample_d     = sample_q;
    thr_d        = thr_q;
    atk_d        = atk_q;
    rel_d        = rel_q;
    env_d        = env_q;
    rem_d        = rem_q;
    gain_d       = gain_q;
    cnt_d        = cnt_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q;
    gain_red_d   = gain_red_q;
    in_ready_d   = (state_d == S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          sample_d = in_sample;
          thr_d    = threshold;
          atk_d    = attack_shift;
          rel_d    = release_shift;
        end
      end
      S_ENV: begin
        env_d  = env_new;
        rem_d  = thr_q;
        gain_d = limit ? '0 : UNITY;
        cnt_d  = CW'(BITS_PER_LEVEL - 1);
      end
      // Quotient bits above the fraction are zero since threshold < env.
      S_DIV: begin
        if (rem_ge) begin
          rem_d  = EW'(rem_sh - {1'b0, env_q});
          gain_d = {gain_q[GW-2:0], 1'b1};
        end else begin
          rem_d  = EW'(rem_sh);
          gain_d = {gain_q[GW-2:0], 1'b0};
        end
        cnt_d = CW'(cnt_q - 1'b1);
      end
      S_APPLY: begin
        out_sample_d = prod_clamped;
        out_valid_d  = 1'b1;
        gain_red_d   = (gain_q != UNITY);
      end
      S_HOLD: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q     <= '0;
      thr_q        <= '0;
      atk_q        <= '0;
      rel_q        <= '0;
      env_q        <= '0;
      rem_q        <= '0;
      gain_q       <= '0;
      cnt_q        <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      gain_red_q   <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      sample_q     <= sample_d;
      thr_q        <= thr_d;
      atk_q        <= atk_d;
      rel_q        <= rel_d;
      env_q        <= env_d;
      rem_q        <= rem_d;
      gain_q       <= gain_d;
      cnt_q        <= cnt_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      gain_red_q   <= gain_red_d;
      in_ready_q   <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_envelope_limiter.sv
// Directed bench for envelope_limiter with an arithmetic reference model
// and a per-cycle output compare process.
module tb_envelope_limiter;

  localparam int BPL   = 12;
  localparam int UNITY = 1 << BPL;

  logic               clk;
  logic               rst_n;
  logic signed [15:0] in_sample;
  logic               in_valid;
  logic               in_ready;
  logic        [14:0] threshold;
  logic        [3:0]  attack_shift;
  logic        [3:0]  release_shift;
  logic signed [15:0] out_sample;
  logic               out_valid;
  logic               out_ready;
  logic               gain_reduction;

  int n_checks = 0;
  int n_fail   = 0;

  int model_env = 0;
  int exp_out   = 0;
  int exp_gr    = 0;
  int exp_lat   = 0;

  envelope_limiter #(.BITS_PER_LEVEL(BPL)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_sample      (in_sample),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .threshold      (threshold),
    .attack_shift   (attack_shift),
    .release_shift  (release_shift),
    .out_sample     (out_sample),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .gain_reduction (gain_reduction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int abs_sat(input int s);
    if (s == -32768) return 32767;
    return (s < 0) ? -s : s;
  endfunction

  // Output must match the model on every cycle it is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      chk("out_sample", int'(out_sample), exp_out);
      chk("gain_reduction", int'(gain_reduction), exp_gr);
      chk("in_ready_busy", int'(in_ready), 0);
    end
  end

  task automatic run_sample(input int s, input int thr, input int atk, input int rel,
                            input int lit_out, input int lit_gr, input int hold);
    int a, gain, lat, w;
    longint p;
    a = abs_sat(s);
    if (a > model_env) model_env = model_env + ((a - model_env) >> atk);
    else               model_env = model_env - ((model_env - a) >> rel);
    gain    = (model_env > thr) ? (thr * UNITY) / model_env : UNITY;
    p       = longint'(s) * longint'(gain);
    exp_out = int'(p >>> BPL);
    exp_gr  = (gain != UNITY) ? 1 : 0;
    exp_lat = (model_env > thr) ? 3 + BPL : 3;
    chk("model_out_pin", exp_out, lit_out);
    chk("model_gr_pin", exp_gr, lit_gr);

    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_idle", int'(in_ready), 1);
    in_sample     = 16'(s);
    threshold     = 15'(thr);
    attack_shift  = 4'(atk);
    release_shift = 4'(rel);
    in_valid      = 1'b1;
    @(posedge clk);
    #1;
    in_valid      = 1'b0;
    in_sample     = 16'($urandom);
    threshold     = 15'($urandom);
    attack_shift  = 4'($urandom);
    release_shift = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    repeat (hold) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_sample = 16'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    rst_n         = 1'b1;
    in_sample     = '0;
    in_valid      = 1'b0;
    threshold     = '0;
    attack_shift  = '0;
    release_shift = '0;
    out_ready     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_gain_red", int'(gain_reduction), 0);
    chk("rst_out_sample", int'(out_sample), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    run_sample(1000, 8192, 0, 0, 1000, 0, 0);
    run_sample(16384, 8192, 0, 0, 8192, 1, 0);
    run_sample(-16384, 8192, 0, 0, -8192, 1, 0);
    run_sample(16384, 8192, 0, 2, 8192, 1, 0);
    run_sample(0, 8192, 0, 2, 0, 1, 0);
    chk("model_env_release", model_env, 12288);
    run_sample(16384, 8192, 1, 2, 9360, 1, 0);
    chk("model_env_attack", model_env, 14336);
    run_sample(-1, 8192, 0, 15, -1, 1, 0);
    run_sample(-32768, 32767, 0, 0, -32768, 0, 0);
    run_sample(-32768, 0, 0, 0, 0, 1, 0);
    run_sample(1000, 8192, 0, 0, 1000, 0, 20);
    run_sample(0, 8192, 0, 15, 0, 0, 0);
    run_sample(20000, 8192, 15, 0, 20000, 0, 0);
    run_sample(16384, 8192, 0, 0, 8192, 1, 0);

    // Abort a limiting sample part way through the divide.
    @(negedge clk);
    in_sample     = 16'sd16384;
    threshold     = 15'd8192;
    attack_shift  = 4'd0;
    release_shift = 4'd0;
    in_valid      = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("gr_before_rst", int'(gain_reduction), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_gain_red", int'(gain_reduction), 0);
    chk("abort_out_sample", int'(out_sample), 0);
    model_env = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_sample(1000, 8192, 0, 0, 1000, 0, 0);
    chk("model_env_post_rst", model_env, 1000);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
